// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one XLEN-bit shifter (srl/sll/sra/pass).
// A round-robin pointer settles contention. The shifted result is captured in a
// single response register and returned with the ID of the requester that issued it.
// The response channel uses valid/ready handshaking.
module shift_arbiter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5      // must equal $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [SHW-1:0]  req0_shamt,
    input  logic [1:0]      req0_type,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [SHW-1:0]  req1_shamt,
    input  logic [1:0]      req1_type,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_id,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    state_t          state_q, state_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            resp_id_q, resp_id_d;
    logic            rr_ptr_q, rr_ptr_d;

    logic [1:0]      valid_vec;
    logic [1:0]      ready_vec;
    logic            grant_id;
    logic            can_accept;
    logic            accept;
    logic [XLEN-1:0] sel_a;
    logic [SHW-1:0]  sel_shamt;
    logic [1:0]      sel_type;
    logic [XLEN-1:0] shift_result;

    // Shared shifter. A shift amount of zero returns the operand for every op type.
    function automatic logic [XLEN-1:0] do_shift(input logic [XLEN-1:0] a,
                                                 input logic [SHW-1:0]  sh,
                                                 input logic [1:0]      op);
        logic [XLEN-1:0] r;
        case (op)
            OP_SRL:  r = a >> sh;
            OP_SLL:  r = a << sh;
            OP_SRA:  r = XLEN'($signed(a) >>> sh);
            default: r = a;
        endcase
        return r;
    endfunction

    assign valid_vec = {req1_valid, req0_valid};

    // Grant selection: a lone valid requester wins; when both are valid, rr_ptr decides.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign can_accept = (state_q == IDLE) || (resp_ready && (state_q == FULL));

    // Each requester sees ready only when it holds the grant. Ready is also held low
    // while reset is asserted.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = rst_n && can_accept && valid_vec[gi]
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    assign accept = |ready_vec;

    assign sel_a        = grant_id ? req1_a     : req0_a;
    assign sel_shamt    = grant_id ? req1_shamt : req0_shamt;
    assign sel_type     = grant_id ? req1_type  : req0_type;
    assign shift_result = do_shift(sel_a, sel_shamt, sel_type);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A new accept takes priority, so a retire and a reload on the same edge stay FULL.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && resp_ready) begin
            state_d = IDLE;
        end
    end

    // Response and pointer next values. These change only on accept, so resp_data holds while empty.
    always_comb begin
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            resp_data_d = shift_result;
            resp_id_d   = grant_id;
            rr_ptr_d    = ~grant_id;
        end
    end

    // Response datapath and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Output decode.
    always_comb begin
        resp_valid = (state_q == FULL);
        resp_data  = resp_data_q;
        resp_id    = resp_id_q;
        req0_ready = ready_vec[0];
        req1_ready = ready_vec[1];
        busy       = (state_q == FULL) || req0_valid || req1_valid;
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [XLEN-1:0] req0_a, req1_a;
    logic [SHW-1:0]  req0_shamt, req1_shamt;
    logic [1:0]      req0_type, req1_type;
    logic            resp_valid, resp_ready, resp_id, busy;
    logic [XLEN-1:0] resp_data;

    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    shift_arbiter #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_type  (req0_type),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_type  (req1_type),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Bit-by-bit reference shifter.
    function automatic logic [XLEN-1:0] model_shift(input logic [XLEN-1:0] a,
                                                    input int sh, input logic [1:0] t);
        logic [XLEN-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            case (t)
                2'b00: begin src = i + sh; r[i] = (src < XLEN) ? a[src] : 1'b0; end
                2'b01: begin src = i - sh; r[i] = (src >= 0) ? a[src] : 1'b0; end
                2'b10: begin src = i + sh; r[i] = (src < XLEN) ? a[src] : a[XLEN-1]; end
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [XLEN-1:0] a,
                           input logic [SHW-1:0] sh, input logic [1:0] t);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_shamt = sh; req0_type = t;
        end else begin
            req1_valid = v; req1_a = a; req1_shamt = sh; req1_type = t;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        resp_ready = 1'b0;
        set_req(0, 1'b1, 32'h1234_5678, 5'd3, 2'b00);
        set_req(1, 1'b0, '0, '0, 2'b00);
        #3;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_data !== '0) begin n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_cmp++; if (resp_id !== 1'b0) begin n_err++; $display("FAIL reset_resp_id: got %b want 0", resp_id); end
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        tick();
        n_cmp++; if (resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_hold: resp_valid=%b req0_ready=%b want 0/0", resp_valid, req0_ready);
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        $display("reset: done");
    endtask

    task automatic test_single_op();
        exp_t e;
        resp_ready = 1'b1;
        set_req(0, 1'b1, 32'h8000_0000, 5'd4, 2'b10);
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", req0_ready); end
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, data: 32'hF800_0000});
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL single_resp_valid: got %b want 1", resp_valid); end
        if (sb.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL single_pop: no expected entry (request not accepted)");
        end else begin
            e = sb.pop_front();
            n_cmp++; if (resp_data !== e.data || resp_id !== e.id) begin
                n_err++; $display("FAIL single_resp: got id=%b data=%h want id=%b data=%h", resp_id, resp_data, e.id, e.data);
            end
        end
        $display("single_op: sra a=80000000 sh=4 -> %h id=%b", resp_data, resp_id);
    endtask

    task automatic test_shift_types();
        exp_t e;
        logic [XLEN-1:0] ta[8];
        logic [SHW-1:0]  ts[8];
        logic [1:0]      tt[8];
        ta[0] = 32'h8000_0000; ts[0] = 5'd4;  tt[0] = 2'b00;
        ta[1] = 32'h0000_0001; ts[1] = 5'd31; tt[1] = 2'b01;
        ta[2] = 32'hDEAD_BEEF; ts[2] = 5'd9;  tt[2] = 2'b11;
        ta[3] = 32'hC000_0001; ts[3] = 5'd0;  tt[3] = 2'b10;
        ta[4] = 32'h7FFF_FFFF; ts[4] = 5'd31; tt[4] = 2'b10;
        for (int i = 5; i < 8; i++) begin
            ta[i] = $urandom; ts[i] = SHW'($urandom_range(0, 31)); tt[i] = 2'(i - 5);
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b1, ta[i], ts[i], tt[i]);
            #1;
            n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                n_err++; $display("FAIL types_ready[%0d]: r0=%b r1=%b want 0/1", i, req0_ready, req1_ready);
            end
            if (req1_valid && req1_ready) sb.push_back('{id: 1'b1, data: model_shift(ta[i], int'(ts[i]), tt[i])});
            tick();
            req1_valid = 1'b0;
            if (sb.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL types_pop[%0d]: no expected entry", i);
            end else begin
                e = sb.pop_front();
                n_cmp++; if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
                    n_err++; $display("FAIL types_resp[%0d]: got v=%b id=%b data=%h want v=1 id=%b data=%h",
                                      i, resp_valid, resp_id, resp_data, e.id, e.data);
                end
            end
            $display("shift_types[%0d]: a=%h sh=%0d t=%b -> %h", i, ta[i], ts[i], tt[i], resp_data);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        logic exp_ptr;
        logic g;
        exp_ptr = 1'b0;   // last accept above was requester 1
        resp_ready = 1'b1;
        set_req(0, 1'b1, $urandom, SHW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        set_req(1, 1'b1, $urandom, SHW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        for (int i = 0; i < 4; i++) begin
            #1;
            g = exp_ptr;
            n_cmp++; if (req0_ready !== (g == 1'b0) || req1_ready !== (g == 1'b1)) begin
                n_err++; $display("FAIL contention_grant[%0d]: r0=%b r1=%b want grant %0d", i, req0_ready, req1_ready, g);
            end
            if (req0_valid && req0_ready)
                sb.push_back('{id: 1'b0, data: model_shift(req0_a, int'(req0_shamt), req0_type)});
            if (req1_valid && req1_ready)
                sb.push_back('{id: 1'b1, data: model_shift(req1_a, int'(req1_shamt), req1_type)});
            exp_ptr = ~g;
            tick();
            if (sb.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL contention_pop[%0d]: no expected entry", i);
            end else begin
                e = sb.pop_front();
                n_cmp++; if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
                    n_err++; $display("FAIL contention_resp[%0d]: got v=%b id=%b data=%h want v=1 id=%b data=%h",
                                      i, resp_valid, resp_id, resp_data, e.id, e.data);
                end
            end
            $display("contention[%0d]: resp_id=%b data=%h", i, resp_id, resp_data);
            // the granted requester presents its next operation
            if (g == 1'b0) set_req(0, 1'b1, $urandom, SHW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            else           set_req(1, 1'b1, $urandom, SHW'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e, held;
        held = '0;
        resp_ready = 1'b1;
        set_req(0, 1'b1, 32'hF0F0_1234, 5'd8, 2'b00);
        #1;
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, data: model_shift(req0_a, 8, 2'b00)});
        tick();
        if (sb.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL bp_first_pop: no expected entry");
        end else begin
            held = sb.pop_front();
            n_cmp++; if (resp_data !== held.data || resp_id !== held.id) begin
                n_err++; $display("FAIL bp_first_resp: got id=%b data=%h want id=%b data=%h", resp_id, resp_data, held.id, held.data);
            end
        end
        resp_ready = 1'b0;
        set_req(0, 1'b1, 32'h8123_4567, 5'd12, 2'b10);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_ready[%0d]: r0=%b r1=%b want 0/0", i, req0_ready, req1_ready);
            end
            tick();
            n_cmp++; if (resp_valid !== 1'b1 || resp_data !== held.data || resp_id !== held.id) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b id=%b data=%h want v=1 id=%b data=%h",
                                  i, resp_valid, resp_id, resp_data, held.id, held.data);
            end
            $display("backpressure[%0d]: held data=%h", i, resp_data);
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", req0_ready); end
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, data: model_shift(req0_a, 12, 2'b10)});
        tick();
        req0_valid = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL bp_release_pop: no expected entry");
        end else begin
            e = sb.pop_front();
            n_cmp++; if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
                n_err++; $display("FAIL bp_release_resp: got v=%b id=%b data=%h want v=1 id=%b data=%h",
                                  resp_valid, resp_id, resp_data, e.id, e.data);
            end
        end
        $display("backpressure: released, data=%h", resp_data);
    endtask

    task automatic test_drain();
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drain_busy_before: got %b want 1", busy); end
        tick();
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL drain_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_busy_after: got %b want 0", busy); end
        $display("drain: resp_valid=%b busy=%b", resp_valid, busy);
    endtask

    task automatic test_async_reset();
        exp_t e;
        resp_ready = 1'b1;
        // accept from req0 so the pointer moves to 1 before reset
        set_req(0, 1'b1, 32'h0000_00FF, 5'd4, 2'b01);
        #1;
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, data: 32'h0000_0FF0});
        tick();
        req0_valid = 1'b0;
        resp_ready = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL areset_pop: no expected entry");
        end else begin
            e = sb.pop_front();
            n_cmp++; if (resp_valid !== 1'b1 || resp_data !== e.data) begin
                n_err++; $display("FAIL areset_full: got v=%b data=%h want v=1 data=%h", resp_valid, resp_data, e.data);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || resp_data !== '0) begin
            n_err++; $display("FAIL areset_clear: got v=%b data=%h want v=0 data=0", resp_valid, resp_data);
        end
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 1'b1, 32'h1111_0000, 5'd16, 2'b00);
        set_req(1, 1'b1, 32'h2222_0000, 5'd16, 2'b00);
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++; $display("FAIL areset_grant: r0=%b r1=%b want 1/0", req0_ready, req1_ready);
        end
        if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, data: 32'h0000_1111});
        if (req1_valid && req1_ready) sb.push_back('{id: 1'b1, data: 32'h0000_2222});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL areset_after_pop: no expected entry");
        end else begin
            e = sb.pop_front();
            n_cmp++; if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
                n_err++; $display("FAIL areset_after_resp: got v=%b id=%b data=%h want v=1 id=%b data=%h",
                                  resp_valid, resp_id, resp_data, e.id, e.data);
            end
        end
        $display("async_reset: post-reset resp id=%b data=%h", resp_id, resp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_shift_types();
        test_contention();
        test_backpressure();
        test_drain();
        test_async_reset();
        n_cmp++; if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (srl/sll/sra/pass) between two requesters: req0 = execute-stage ALU, req1 = load/store alignment unit.
- Each requester port uses a valid/ready handshake.
- Arbitration is round-robin.
- The shifted result is registered and returned on a single response channel, tagged with the requester ID, with response-side backpressure.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  XLEN  requester 0 operand.
- req0_shamt  in  SHW  requester 0 shift amount.
- req0_type  in  2  requester 0 op: 00 srl, 01 sll, 10 sra, 11 pass.
- req1_valid, req1_ready, req1_a, req1_shamt, req1_type: same definitions as the req0_* ports, for requester 1.
- resp_valid  out  1  response register holds an unconsumed result.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_data  out  XLEN  shifted result.
- resp_id  out  1  requester that issued the result (0/1).
- busy  out  1  high when resp_valid=1 or any req*_valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0 (req0 has priority).
  - req*_ready=0 while reset is asserted.
- States:
  - IDLE: response register empty.
  - FULL: response register holds a result.
- can_accept = (state==IDLE) | (resp_ready & state==FULL).
- Grant, combinational:
  - Only one valid requester: it is granted.
  - Both valid: requester rr_ptr is granted.
  - reqN_ready = can_accept & grant==N.
  - At most one ready is high per cycle.
- Accept (reqN_valid & reqN_ready at posedge):
  - resp_data <= shift(reqN_a, reqN_shamt, reqN_type); resp_id <= N.
  - State becomes FULL; rr_ptr <= ~N.
  - rr_ptr updates only on accept.
- Latency: 1 cycle from accept to resp_valid=1.
- Throughput: 1 op/cycle when resp_ready is held high. If FULL, resp_ready=1 and a request is valid, the old response retires and the new one loads in the same edge; resp_valid stays 1.
- FULL with resp_ready=1 and no valid request: go to IDLE, resp_valid=0.
- FULL with resp_ready=0: resp_data, resp_id and resp_valid hold; both ready outputs are 0.
- Shift semantics:
  - srl: zero-fill.
  - sll: zero-fill.
  - sra: sign-fill from a[XLEN-1]; the operand must be treated as signed.
  - pass: result = a.
  - shamt=0: result = a for all types.
- Requester rules:
  - A requester must hold valid and its operands stable until ready is high.
  - The arbiter does not register or alter unaccepted requests.
  - The grant may move to the other requester only when the holding requester's valid drops; no preemption mid-handshake is needed because grant and accept occur in the same cycle.
- Reset mid-operation: a pending response is discarded; resp_valid=0 immediately on rst_n falling.
- resp_data is don't-care when resp_valid=0, but must hold its last value (no glitch toggling).

Test Plan:
- Reset then single op: req0 a=0x80000000, shamt=4, type=10 → req0_ready=1 that cycle; next cycle resp_valid=1, resp_data=0xF8000000, resp_id=0.
- Shift types with resp_ready=1:
  - req1 a=0x80000000, shamt=4, type=00 → resp_data=0x08000000, resp_id=1.
  - type=01, a=0x00000001, shamt=31 → resp_data=0x80000000.
  - type=11 → resp_data=a.
- Contention: both valid continuously for 4 cycles with resp_ready=1 → grants alternate 0,1,0,1; resp_id sequence 0,1,0,1; resp_valid stays high every cycle after the first.
- Backpressure: after one accept, hold resp_ready=0 for 3 cycles with req0 valid → req0_ready=0 and resp_data unchanged for those cycles; raising resp_ready accepts req0 in the same cycle, and the next result appears one cycle later.
- Drain: FULL, resp_ready=1, no valid request → next cycle resp_valid=0, state IDLE, busy=0.
- Asynchronous reset while FULL: assert rst_n=0 between clock edges → resp_valid=0 immediately; after release, a request from req0 is granted first (rr_ptr=0).
